// File: rtl/adc_capture_ctrl_pkg.sv
// Shared types and defaults for the ADC capture sequencer slice.
package adc_capture_pkg;

  localparam int unsigned DEF_WDTH           = 16;
  localparam int unsigned DEF_DEPTH          = 64;
  localparam int unsigned DEF_SETTLE_SAMPLES = 4;
  localparam int unsigned DEF_CNT_W          = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // One extra MSB beyond the address lets equal addresses mean either empty or full.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Sample output stream (valid/ready) from the capture controller to its consumer.
interface adc_capture_if
  import adc_capture_pkg::*;
#(
  parameter int unsigned WDTH = DEF_WDTH
);

  logic [WDTH-1:0] m_data;
  logic            m_valid;
  logic            m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/adc_capture_ctrl_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head entry and flush.
module adc_sample_fifo
  import adc_capture_pkg::*;
#(
  parameter int unsigned WDTH  = DEF_WDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push,
  input  logic [WDTH-1:0] push_data,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output logic [WDTH-1:0] head_data,
  output logic            head_valid
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WDTH-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   rd_next;
  logic            pop_ok;
  logic            push_ok;
  logic            head_next;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop_ok    = pop && head_valid;
  assign push_ok   = push && (!full || pop_ok);
  assign rd_next   = rd_ptr + PW'(pop_ok);
  // Head looks at the pre-push write pointer, so a fresh word appears one edge after its write.
  assign head_next = (wr_ptr != rd_next);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr     <= rd_next;
      head_valid <= head_next;
      if (head_next) begin
        head_data <= mem[rd_next[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer: enable ADC, discard warm-up samples, capture a window into a FIFO, stream it out.
// Optional min/max tracking of captured samples is enabled by defining ADC_CAPTURE_PEAK_EN.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int unsigned WDTH           = DEF_WDTH,
  parameter int unsigned DEPTH          = DEF_DEPTH,
  parameter int unsigned SETTLE_SAMPLES = DEF_SETTLE_SAMPLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_samples,
  output logic             adc_en,
  input  logic [WDTH-1:0]  adc_output,
  input  logic             adc_valid,
  adc_capture_if.master    m,
  output logic             busy,
  output logic             done,
  output logic             overflow
`ifdef ADC_CAPTURE_PEAK_EN
  ,
  output logic [WDTH-1:0]  peak_min,
  output logic [WDTH-1:0]  peak_max
`endif
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] num_lat;
  logic             accept;
  logic             push;
  logic             flush;
  logic             pop;
  logic             drop;
  logic             done_next;
  logic             cap_valid;
  logic             settle_valid;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WDTH-1:0]  head_data;
  logic             head_valid;

  assign cnt_inc      = cnt + CNT_W'(1);
  assign pop          = m.m_valid && m.m_ready;
  assign cap_valid    = (state == CAPTURE) && adc_valid && !abort;
  assign settle_valid = (state == SETTLE) && adc_valid && !abort;
  assign drop         = push && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    done_next  = 1'b0;
    if (abort) begin
      state_next = IDLE;
      flush      = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            accept = 1'b1;
            if (num_samples == '0) begin
              state_next = DRAIN;
            end else if (SETTLE_SAMPLES != 0) begin
              state_next = SETTLE;
            end else begin
              state_next = CAPTURE;
            end
          end
        end
        SETTLE: begin
          if (adc_valid && (cnt_inc == CNT_W'(SETTLE_SAMPLES))) begin
            state_next = CAPTURE;
          end
        end
        CAPTURE: begin
          if (adc_valid) begin
            push = 1'b1;
            if (cnt_inc == num_lat) begin
              state_next = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // One counter serves both phases; it restarts when settling hands over to capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      num_lat  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= done_next;
      if (accept) begin
        cnt      <= '0;
        num_lat  <= num_samples;
        overflow <= 1'b0;
      end else if (settle_valid) begin
        cnt <= (state_next == CAPTURE) ? '0 : cnt_inc;
      end else if (cap_valid) begin
        cnt <= cnt_inc;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef ADC_CAPTURE_PEAK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak_min <= '0;
      peak_max <= '0;
    end else if (accept) begin
      peak_min <= '1;
      peak_max <= '0;
    end else if (cap_valid) begin
      if (adc_output < peak_min) begin
        peak_min <= adc_output;
      end
      if (adc_output > peak_max) begin
        peak_max <= adc_output;
      end
    end
  end
`endif

  adc_sample_fifo #(
    .WDTH  (WDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (push),
    .push_data  (adc_output),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_data  (head_data),
    .head_valid (head_valid)
  );

  assign m.m_data  = head_data;
  assign m.m_valid = head_valid;
  assign adc_en    = (state == SETTLE) || (state == CAPTURE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed self-checking bench for adc_capture_ctrl (DEPTH=4, SETTLE_SAMPLES=4).
module tb_adc_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] num_samples;
  logic        adc_en;
  logic [15:0] adc_output;
  logic        adc_valid;
  logic        busy;
  logic        done;
  logic        overflow;
`ifdef ADC_CAPTURE_PEAK_EN
  logic [15:0] peak_min;
  logic [15:0] peak_max;
`endif

  int          checks = 0;
  int          passed = 0;
  int          done_cnt = 0;
  logic        en_seen = 1'b0;
  logic [15:0] rx_q[$];
  logic [15:0] got;

  adc_capture_if #(.WDTH(16)) bus ();

  adc_capture_ctrl #(
    .WDTH           (16),
    .DEPTH          (4),
    .SETTLE_SAMPLES (4),
    .CNT_W          (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .num_samples (num_samples),
    .adc_en      (adc_en),
    .adc_output  (adc_output),
    .adc_valid   (adc_valid),
    .m           (bus.master),
    .busy        (busy),
    .done        (done),
`ifdef ADC_CAPTURE_PEAK_EN
    .peak_min    (peak_min),
    .peak_max    (peak_max),
`endif
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Inputs are stable mid-cycle, so a transfer seen here happens at the next rising edge.
  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) rx_q.push_back(bus.m_data);
    if (done) done_cnt++;
    if (adc_en) en_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v, input int gap);
    adc_output = v;
    adc_valid  = 1'b1;
    tick();
    adc_valid  = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pulse_start(input logic [15:0] n);
    num_samples = n;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 200 && busy; n++) tick();
    checks++; if (busy !== 1'b0) $display("FAIL %s_timeout busy=%0b exp 0", name, busy); else passed++;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_samples = '0;
    adc_output = '0; adc_valid = 1'b0; bus.m_ready = 1'b0;
    repeat (3) tick();
    checks++; if (adc_en !== 1'b0) $display("FAIL reset_adc_en got %0b exp 0", adc_en); else passed++;
    checks++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid got %0b exp 0", bus.m_valid); else passed++;
    checks++; if (bus.m_data !== 16'h0) $display("FAIL reset_m_data got %h exp 0000", bus.m_data); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %0b exp 0", done); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b exp 0", overflow); else passed++;
`ifdef ADC_CAPTURE_PEAK_EN
    checks++; if (peak_min !== 16'h0 || peak_max !== 16'h0) $display("FAIL reset_peak got %h/%h exp 0000/0000", peak_min, peak_max); else passed++;
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_settle_discard();
    rx_q.delete(); done_cnt = 0; bus.m_ready = 1'b1;
    pulse_start(16'd8);
    checks++; if (adc_en !== 1'b1) $display("FAIL settle_en_start got %0b exp 1", adc_en); else passed++;
    for (int i = 1; i <= 12; i++) begin
      adc_output = 16'(i);
      adc_valid  = 1'b1;
      tick();
      adc_valid  = 1'b0;
      if (i == 11) begin
        checks++; if (adc_en !== 1'b1) $display("FAIL settle_en_11 got %0b exp 1", adc_en); else passed++;
      end
      if (i == 12) begin
        checks++; if (adc_en !== 1'b0) $display("FAIL settle_en_12 got %0b exp 0", adc_en); else passed++;
      end
      repeat (255) tick();
    end
    wait_idle("settle");
    checks++; if (rx_q.size() != 8) $display("FAIL settle_count got %0d exp 8", rx_q.size()); else passed++;
    for (int i = 0; i < 8; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 16'hxxxx;
      checks++; if (got !== 16'(i + 5)) $display("FAIL settle_data%0d got %0d exp %0d", i, got, i + 5); else passed++;
    end
    checks++; if (done_cnt != 1) $display("FAIL settle_done got %0d exp 1", done_cnt); else passed++;
  endtask

  task automatic test_overflow();
    rx_q.delete(); done_cnt = 0; bus.m_ready = 1'b0;
    pulse_start(16'd10);
    for (int i = 0; i < 4; i++) send(16'd900, 1);
    for (int i = 1; i <= 10; i++) send(16'(i), 1);
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %0b exp 1", overflow); else passed++;
    checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 16'd1) $display("FAIL ovf_head got %0b/%0d exp 1/1", bus.m_valid, bus.m_data); else passed++;
    bus.m_ready = 1'b1;
    wait_idle("ovf");
    checks++; if (rx_q.size() != 4) $display("FAIL ovf_count got %0d exp 4", rx_q.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 16'hxxxx;
      checks++; if (got !== 16'(i + 1)) $display("FAIL ovf_data%0d got %0d exp %0d", i, got, i + 1); else passed++;
    end
    checks++; if (done_cnt != 1) $display("FAIL ovf_done got %0d exp 1", done_cnt); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %0b exp 1", overflow); else passed++;
  endtask

  task automatic test_full_pop();
    rx_q.delete(); done_cnt = 0; bus.m_ready = 1'b0;
    pulse_start(16'd5);
    checks++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf_clr got %0b exp 0", overflow); else passed++;
    for (int i = 0; i < 4; i++) send(16'd777, 1);
    for (int i = 1; i <= 4; i++) send(16'(i), 1);
    adc_output  = 16'd5;
    adc_valid   = 1'b1;
    bus.m_ready = 1'b1;
    tick();
    adc_valid   = 1'b0;
    bus.m_ready = 1'b0;
    checks++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf got %0b exp 0", overflow); else passed++;
    checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 16'd2) $display("FAIL fullpop_head got %0b/%0d exp 1/2", bus.m_valid, bus.m_data); else passed++;
    bus.m_ready = 1'b1;
    wait_idle("fullpop");
    checks++; if (rx_q.size() != 5) $display("FAIL fullpop_count got %0d exp 5", rx_q.size()); else passed++;
    for (int i = 0; i < 5; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 16'hxxxx;
      checks++; if (got !== 16'(i + 1)) $display("FAIL fullpop_data%0d got %0d exp %0d", i, got, i + 1); else passed++;
    end
    checks++; if (done_cnt != 1) $display("FAIL fullpop_done got %0d exp 1", done_cnt); else passed++;
  endtask

  task automatic test_abort();
    rx_q.delete(); done_cnt = 0; bus.m_ready = 1'b0;
    pulse_start(16'd8);
    for (int i = 0; i < 4; i++) send(16'd1234, 1);
    for (int i = 0; i < 3; i++) send(16'(10 + i), 1);
    checks++; if (bus.m_valid !== 1'b1) $display("FAIL abort_pre_valid got %0b exp 1", bus.m_valid); else passed++;
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %0b exp 0", busy); else passed++;
    checks++; if (adc_en !== 1'b0) $display("FAIL abort_en got %0b exp 0", adc_en); else passed++;
    checks++; if (bus.m_valid !== 1'b0) $display("FAIL abort_valid got %0b exp 0", bus.m_valid); else passed++;
    repeat (5) tick();
    checks++; if (done_cnt != 0) $display("FAIL abort_no_done got %0d exp 0", done_cnt); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL abort_stays_idle got %0b exp 0", busy); else passed++;
    bus.m_ready = 1'b1;
    pulse_start(16'd2);
    for (int i = 0; i < 4; i++) send(16'd4321, 1);
    send(16'h0055, 1);
    send(16'h0066, 1);
    wait_idle("abort_restart");
    checks++; if (rx_q.size() != 2) $display("FAIL abort_restart_count got %0d exp 2", rx_q.size()); else passed++;
    got = (rx_q.size() > 0) ? rx_q[0] : 16'hxxxx;
    checks++; if (got !== 16'h0055) $display("FAIL abort_restart_d0 got %h exp 0055", got); else passed++;
    got = (rx_q.size() > 1) ? rx_q[1] : 16'hxxxx;
    checks++; if (got !== 16'h0066) $display("FAIL abort_restart_d1 got %h exp 0066", got); else passed++;
    checks++; if (done_cnt != 1) $display("FAIL abort_restart_done got %0d exp 1", done_cnt); else passed++;
  endtask

  task automatic test_zero_and_busy_start();
    rx_q.delete(); done_cnt = 0; bus.m_ready = 1'b1;
    tick();
    en_seen = 1'b0;
    pulse_start(16'd0);
    checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL zero_drain got busy=%0b done=%0b exp 1/0", busy, done); else passed++;
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL zero_done got done=%0b busy=%0b exp 1/0", done, busy); else passed++;
    tick();
    checks++; if (done !== 1'b0) $display("FAIL zero_done_pulse got %0b exp 0", done); else passed++;
    checks++; if (en_seen !== 1'b0) $display("FAIL zero_en_seen got %0b exp 0", en_seen); else passed++;
    done_cnt = 0;
    pulse_start(16'd3);
    for (int i = 0; i < 4; i++) send(16'd999, 1);
    send(16'd20, 1);
    pulse_start(16'd1);
    send(16'd21, 0);
    checks++; if (adc_en !== 1'b1) $display("FAIL busystart_en_mid got %0b exp 1", adc_en); else passed++;
    send(16'd22, 0);
    checks++; if (adc_en !== 1'b0) $display("FAIL busystart_en_end got %0b exp 0", adc_en); else passed++;
    wait_idle("busystart");
    checks++; if (rx_q.size() != 3) $display("FAIL busystart_count got %0d exp 3", rx_q.size()); else passed++;
    for (int i = 0; i < 3; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 16'hxxxx;
      checks++; if (got !== 16'(20 + i)) $display("FAIL busystart_data%0d got %0d exp %0d", i, got, 20 + i); else passed++;
    end
    checks++; if (done_cnt != 1) $display("FAIL busystart_done got %0d exp 1", done_cnt); else passed++;
  endtask

`ifdef ADC_CAPTURE_PEAK_EN
  task automatic test_peak();
    rx_q.delete(); done_cnt = 0; bus.m_ready = 1'b1;
    pulse_start(16'd4);
    checks++; if (peak_min !== 16'hFFFF || peak_max !== 16'h0) $display("FAIL peak_init got %h/%h exp ffff/0000", peak_min, peak_max); else passed++;
    for (int i = 0; i < 4; i++) send(16'd5000, 1);
    send(16'd300, 1);
    send(16'd100, 1);
    send(16'd900, 1);
    send(16'd500, 1);
    wait_idle("peak");
    checks++; if (peak_min !== 16'd100) $display("FAIL peak_min got %0d exp 100", peak_min); else passed++;
    checks++; if (peak_max !== 16'd900) $display("FAIL peak_max got %0d exp 900", peak_max); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_settle_discard();
    test_overflow();
    test_full_pop();
    test_abort();
    test_zero_and_busy_start();
`ifdef ADC_CAPTURE_PEAK_EN
    test_peak();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
